// File: rtl/gc_command_translator_if.sv
// Bus bundle for gc_command_translator: GC command FIFO pop side, DRAM read port, and
// flash channel command write side.
interface gc_command_translator_if #(
    parameter int unsigned DRAM_IO_WIDTH    = 256,
    parameter int unsigned DRAM_ADDR_WIDTH  = 29,
    parameter int unsigned COMMAND_WIDTH    = 128,
    parameter int unsigned GC_COMMAND_WIDTH = 29
);
    logic                        gc_command_fifo_empty;
    logic [GC_COMMAND_WIDTH-1:0] gc_command_fifo_out;
    logic                        gc_command_fifo_rd_en;

    logic                        dram_request;
    logic                        dram_permit;
    logic                        release_dram;
    logic                        dram_en;
    logic                        dram_read_or_write;
    logic [DRAM_ADDR_WIDTH-1:0]  addr_to_dram;
    logic                        dram_ready;
    logic                        rd_data_valid;
    logic [DRAM_IO_WIDTH-1:0]    data_from_dram;

    logic                        command_fifo_prog_full;
    logic [COMMAND_WIDTH-1:0]    command_out;
    logic                        command_out_en;

    modport master (
        input  gc_command_fifo_empty, gc_command_fifo_out,
        output gc_command_fifo_rd_en,
        output dram_request, release_dram, dram_en, dram_read_or_write, addr_to_dram,
        input  dram_permit, dram_ready, rd_data_valid, data_from_dram,
        input  command_fifo_prog_full,
        output command_out, command_out_en
    );

    modport slave (
        output gc_command_fifo_empty, gc_command_fifo_out,
        input  gc_command_fifo_rd_en,
        input  dram_request, release_dram, dram_en, dram_read_or_write, addr_to_dram,
        output dram_permit, dram_ready, rd_data_valid, data_from_dram,
        output command_fifo_prog_full,
        input  command_out, command_out_en
    );
endinterface

// File: rtl/gc_command_translator.sv
// Pops GC commands, resolves MOVE logical pages through the DRAM L2P table and emits flash commands.
// Define GC_TRANSLATOR_STATS_EN to add move/erase/stale-drop event counters.
module gc_command_translator #(
    parameter int unsigned PHYSICAL_ADDR_WIDTH = 25,
    parameter int unsigned DRAM_IO_WIDTH       = 256,
    parameter int unsigned DRAM_ADDR_WIDTH     = 29,
    parameter int unsigned COMMAND_WIDTH       = 128,
    parameter int unsigned GC_COMMAND_WIDTH    = 29,
    parameter logic [DRAM_ADDR_WIDTH-1:0] L2P_TABLE_BASE = 29'h0,
    parameter logic [1:0] MOVE  = 2'b10,
    parameter logic [1:0] ERASE = 2'b11
) (
    input  logic        clk,
    input  logic        reset,
`ifdef GC_TRANSLATOR_STATS_EN
    output logic [31:0] move_count,
    output logic [31:0] erase_count,
    output logic [31:0] stale_drop_count,
`endif
    gc_command_translator_if.master bus
);
    localparam int unsigned LOGICAL_W = GC_COMMAND_WIDTH - 1;
    localparam int unsigned ENTRY_W   = 32;
    localparam int unsigned BUF_W     = 2 * DRAM_IO_WIDTH;
    localparam int unsigned PAD_W     = COMMAND_WIDTH - 2 - PHYSICAL_ADDR_WIDTH - LOGICAL_W;
    localparam int unsigned ERASE_BIT = GC_COMMAND_WIDTH - 1;

    typedef enum logic [3:0] {
        IDLE, POP, LATCH, APPLY_DRAM, WAIT_PERMIT, READ_CMD,
        RECV0, RECV1, EXTRACT, CHECK, WAIT_OUT
    } state_t;

    state_t                         state_q, state_d;
    logic [GC_COMMAND_WIDTH-1:0]    cmd_q, cmd_d;
    logic [BUF_W-1:0]               buf_q, buf_d;
    logic [ENTRY_W-1:0]             entry_q, entry_d;
    logic [PHYSICAL_ADDR_WIDTH-1:0] phys_q, phys_d;
    logic                           rd_en_q, rd_en_d;
    logic                           request_q, request_d;
    logic                           release_q, release_d;
    logic                           dram_en_q, dram_en_d;
    logic                           read_q, read_d;
    logic [DRAM_ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [COMMAND_WIDTH-1:0]       cmd_out_q, cmd_out_d;
    logic                           cmd_out_en_q, cmd_out_en_d;
`ifdef GC_TRANSLATOR_STATS_EN
    logic [31:0] move_cnt_q, move_cnt_d;
    logic [31:0] erase_cnt_q, erase_cnt_d;
    logic [31:0] stale_cnt_q, stale_cnt_d;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cmd_q        <= '0;
            buf_q        <= '0;
            entry_q      <= '0;
            phys_q       <= '0;
            rd_en_q      <= 1'b0;
            request_q    <= 1'b0;
            release_q    <= 1'b0;
            dram_en_q    <= 1'b0;
            read_q       <= 1'b0;
            addr_q       <= '0;
            cmd_out_q    <= '0;
            cmd_out_en_q <= 1'b0;
`ifdef GC_TRANSLATOR_STATS_EN
            move_cnt_q   <= '0;
            erase_cnt_q  <= '0;
            stale_cnt_q  <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            buf_q        <= buf_d;
            entry_q      <= entry_d;
            phys_q       <= phys_d;
            rd_en_q      <= rd_en_d;
            request_q    <= request_d;
            release_q    <= release_d;
            dram_en_q    <= dram_en_d;
            read_q       <= read_d;
            addr_q       <= addr_d;
            cmd_out_q    <= cmd_out_d;
            cmd_out_en_q <= cmd_out_en_d;
`ifdef GC_TRANSLATOR_STATS_EN
            move_cnt_q   <= move_cnt_d;
            erase_cnt_q  <= erase_cnt_d;
            stale_cnt_q  <= stale_cnt_d;
`endif
        end
    end

    // Level outputs hold by default; rd_en, release and command strobe are single-cycle pulses.
    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        buf_d        = buf_q;
        entry_d      = entry_q;
        phys_d       = phys_q;
        rd_en_d      = 1'b0;
        request_d    = request_q;
        release_d    = 1'b0;
        dram_en_d    = dram_en_q;
        read_d       = read_q;
        addr_d       = addr_q;
        cmd_out_d    = cmd_out_q;
        cmd_out_en_d = 1'b0;
`ifdef GC_TRANSLATOR_STATS_EN
        move_cnt_d   = move_cnt_q;
        erase_cnt_d  = erase_cnt_q;
        stale_cnt_d  = stale_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (!bus.gc_command_fifo_empty) begin
                    rd_en_d = 1'b1;
                    state_d = POP;
                end
            end
            // FIFO read data becomes valid the cycle after the pop strobe.
            POP: state_d = LATCH;
            LATCH: begin
                cmd_d = bus.gc_command_fifo_out;
                if (bus.gc_command_fifo_out[ERASE_BIT]) begin
                    phys_d  = bus.gc_command_fifo_out[PHYSICAL_ADDR_WIDTH-1:0];
                    state_d = WAIT_OUT;
                end else begin
                    state_d = APPLY_DRAM;
                end
            end
            APPLY_DRAM: begin
                request_d = 1'b1;
                state_d   = WAIT_PERMIT;
            end
            WAIT_PERMIT: begin
                if (bus.dram_permit) begin
                    request_d = 1'b0;
                    dram_en_d = 1'b1;
                    read_d    = 1'b1;
                    addr_d    = L2P_TABLE_BASE
                              + DRAM_ADDR_WIDTH'({cmd_q[LOGICAL_W-1:4], 3'b000});
                    state_d   = READ_CMD;
                end
            end
            READ_CMD: begin
                if (bus.dram_ready) begin
                    dram_en_d = 1'b0;
                    read_d    = 1'b0;
                    state_d   = RECV0;
                end
            end
            RECV0: begin
                if (bus.rd_data_valid) begin
                    buf_d[DRAM_IO_WIDTH-1:0] = bus.data_from_dram;
                    state_d = RECV1;
                end
            end
            RECV1: begin
                if (bus.rd_data_valid) begin
                    buf_d[BUF_W-1:DRAM_IO_WIDTH] = bus.data_from_dram;
                    state_d = EXTRACT;
                end
            end
            EXTRACT: begin
                entry_d = buf_q[{cmd_q[3:0], 5'd0} +: ENTRY_W];
                state_d = CHECK;
            end
            // DRAM is released here on both the resolved and the stale path.
            CHECK: begin
                release_d = 1'b1;
                if (entry_q == {ENTRY_W{1'b1}}) begin
`ifdef GC_TRANSLATOR_STATS_EN
                    stale_cnt_d = stale_cnt_q + 32'd1;
`endif
                    state_d = IDLE;
                end else begin
                    phys_d  = entry_q[PHYSICAL_ADDR_WIDTH-1:0];
                    state_d = WAIT_OUT;
                end
            end
            WAIT_OUT: begin
                if (!bus.command_fifo_prog_full) begin
                    cmd_out_en_d = 1'b1;
                    if (cmd_q[ERASE_BIT]) begin
                        cmd_out_d = {ERASE, phys_q, {LOGICAL_W{1'b0}}, {PAD_W{1'b0}}};
`ifdef GC_TRANSLATOR_STATS_EN
                        erase_cnt_d = erase_cnt_q + 32'd1;
`endif
                    end else begin
                        cmd_out_d = {MOVE, phys_q, cmd_q[LOGICAL_W-1:0], {PAD_W{1'b0}}};
`ifdef GC_TRANSLATOR_STATS_EN
                        move_cnt_d = move_cnt_q + 32'd1;
`endif
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.gc_command_fifo_rd_en = rd_en_q;
    assign bus.dram_request          = request_q;
    assign bus.release_dram          = release_q;
    assign bus.dram_en               = dram_en_q;
    assign bus.dram_read_or_write    = read_q;
    assign bus.addr_to_dram          = addr_q;
    assign bus.command_out           = cmd_out_q;
    assign bus.command_out_en        = cmd_out_en_q;
`ifdef GC_TRANSLATOR_STATS_EN
    assign move_count       = move_cnt_q;
    assign erase_count      = erase_cnt_q;
    assign stale_drop_count = stale_cnt_q;
`endif
endmodule
